twiddle_index_align: RTL and testbench

Aligns per-lane twiddle-index words from an earlier FFT stage with those of a later stage and emits their per-lane sum for the next stage's twiddle lookup. It replaces a fixed-depth index delay line plus a combinational adder with a handshake-driven FIFO, so alignment holds even when upstream latency varies. It also conjugates the index for IFFT, reports occupancy and flags misalignment. It sits between the second and third SDF stages of the FFT datapath.

---
 rtl/twiddle_index_pkg.sv | 18 +
 rtl/index_fifo_ram.sv | 27 ++
 rtl/twiddle_index_align.sv | 99 +++++++++
 tb/tb_twiddle_index_align.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/twiddle_index_pkg.sv
// Shared constants and helpers for the twiddle-index alignment FIFO.
package twiddle_index_pkg;
    localparam int DEF_LANES     = 16;
    localparam int DEF_WIDTH_A   = 5;
    localparam int DEF_WIDTH_B   = 5;
    localparam int DEF_WIDTH_OUT = 6;
    localparam int DEF_DEPTH     = 256;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Two's-complement negation; the caller keeps the low WIDTH_OUT bits,
    // which is (2^WIDTH_OUT - s) mod 2^WIDTH_OUT.
    function automatic logic [31:0] conj_index(input logic [31:0] s);
        return 32'd0 - s;
    endfunction
endpackage

// File: rtl/index_fifo_ram.sv
// Simple dual-port RAM with registered read; a same-address write returns the old word.
module index_fifo_ram #(
    parameter int W     = 80,
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Only the read register is reset so the output sum starts at zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)   rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/twiddle_index_align.sv
// Pairs early-stage index words (buffered in a FIFO) with late-stage words and emits their per-lane sum.
module twiddle_index_align
    import twiddle_index_pkg::*;
#(
    parameter int LANES     = DEF_LANES,
    parameter int WIDTH_A   = DEF_WIDTH_A,
    parameter int WIDTH_B   = DEF_WIDTH_B,
    parameter int WIDTH_OUT = DEF_WIDTH_OUT,
    parameter int DEPTH     = DEF_DEPTH
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  fft_mode,
    input  logic                                  clear,
    input  logic                                  a_valid,
    input  logic [LANES-1:0][WIDTH_A-1:0]         a_index,
    input  logic                                  b_valid,
    input  logic [LANES-1:0][WIDTH_B-1:0]         b_index,
    output logic                                  sum_valid,
    output logic [LANES-1:0][WIDTH_OUT-1:0]       sum_index,
    output logic [$clog2(DEPTH):0]                fill_level,
    output logic                                  overflow,
    output logic                                  underflow
);
    localparam int AW = ptr_width(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]                  wptr, rptr;
    logic [CW-1:0]                  count;
    logic                           full, empty, push, pop;
    logic [LANES-1:0][WIDTH_B-1:0]  b_q;
    logic                           fft_q;
    logic [LANES*WIDTH_A-1:0]       rdata;
    logic [LANES-1:0][WIDTH_A-1:0]  a_rd;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    // A pop frees a slot in the same cycle, so a full FIFO still accepts a write alongside it.
    assign pop   = !clear && b_valid && !empty;
    assign push  = !clear && a_valid && (!full || pop);

    index_fifo_ram #(.W(LANES*WIDTH_A), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .rstn  (rstn),
        .we    (push),
        .waddr (wptr),
        .wdata (a_index),
        .re    (pop),
        .raddr (rptr),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            sum_valid <= 1'b0;
            b_q       <= '0;
            fft_q     <= 1'b1;
        end else if (clear) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            sum_valid <= 1'b0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (a_valid && full && !pop) overflow  <= 1'b1;
            if (b_valid && empty)        underflow <= 1'b1;
            sum_valid <= pop;
            if (pop) begin
                b_q   <= b_index;
                fft_q <= fft_mode;
            end
        end
    end

    // The RAM read register and b_q/fft_q all load in the pop cycle, so the
    // adder after them yields the result one cycle later and holds it between pops.
    assign a_rd = rdata;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [WIDTH_OUT-1:0] s;
        assign s = WIDTH_OUT'(a_rd[i]) + WIDTH_OUT'(b_q[i]);
        assign sum_index[i] = fft_q ? s : WIDTH_OUT'(conj_index(32'(s)));
    end

    assign fill_level = count;
endmodule

// File: tb/tb_twiddle_index_align.sv
// Directed and random checks of twiddle_index_align across three FIFO depths sharing one stimulus.
module tb_twiddle_index_align;
    localparam int L  = 16;
    localparam int WA = 5;
    localparam int WB = 5;
    localparam int WO = 6;

    typedef logic [L-1:0][WA-1:0] a_t;
    typedef logic [L-1:0][WB-1:0] b_t;
    typedef logic [L-1:0][WO-1:0] s_t;
    typedef struct { s_t data; int cyc; } exp_t;

    logic clk = 1'b0, rstn = 1'b0, fft_mode = 1'b1, clear = 1'b0;
    logic a_valid = 1'b0, b_valid = 1'b0;
    a_t   a_index = '0;
    b_t   b_index = '0;

    always #5 clk = ~clk;

    logic       sv0, sv1, sv2, ov0, ov1, ov2, ud0, ud1, ud2;
    s_t         si0, si1, si2;
    logic [8:0] fl0;
    logic [2:0] fl1;
    logic [3:0] fl2;

    twiddle_index_align #(.DEPTH(256)) u_big (
        .clk(clk), .rstn(rstn), .fft_mode(fft_mode), .clear(clear),
        .a_valid(a_valid), .a_index(a_index), .b_valid(b_valid), .b_index(b_index),
        .sum_valid(sv0), .sum_index(si0), .fill_level(fl0), .overflow(ov0), .underflow(ud0));
    twiddle_index_align #(.DEPTH(4)) u_four (
        .clk(clk), .rstn(rstn), .fft_mode(fft_mode), .clear(clear),
        .a_valid(a_valid), .a_index(a_index), .b_valid(b_valid), .b_index(b_index),
        .sum_valid(sv1), .sum_index(si1), .fill_level(fl1), .overflow(ov1), .underflow(ud1));
    twiddle_index_align #(.DEPTH(8)) u_eight (
        .clk(clk), .rstn(rstn), .fft_mode(fft_mode), .clear(clear),
        .a_valid(a_valid), .a_index(a_index), .b_valid(b_valid), .b_index(b_index),
        .sum_valid(sv2), .sum_index(si2), .fill_level(fl2), .overflow(ov2), .underflow(ud2));

    int   sel = 0;
    logic o_sv, o_ov, o_ud;
    s_t   o_si;
    int   o_fl;

    always_comb begin
        o_sv = sv0; o_si = si0; o_fl = int'(fl0); o_ov = ov0; o_ud = ud0;
        case (sel)
            1: begin o_sv = sv1; o_si = si1; o_fl = int'(fl1); o_ov = ov1; o_ud = ud1; end
            2: begin o_sv = sv2; o_si = si2; o_fl = int'(fl2); o_ov = ov2; o_ud = ud2; end
            default: ;
        endcase
    end

    int   vectors = 0, errs = 0, cyc = 0;
    exp_t sb[$];
    a_t   mq[$];
    logic m_ov = 1'b0, m_ud = 1'b0;
    int   depth_of[3] = '{256, 4, 8};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic s_t calc(input a_t a, input b_t b, input logic m);
        s_t r;
        for (int i = 0; i < L; i++) begin
            logic [WO-1:0] s;
            s = WO'(a[i]) + WO'(b[i]);
            r[i] = m ? s : WO'(7'd64 - 7'(s));
        end
        return r;
    endfunction

    function automatic a_t all_a(input int v);
        a_t r;
        for (int i = 0; i < L; i++) r[i] = WA'(v);
        return r;
    endfunction

    function automatic b_t all_b(input int v);
        b_t r;
        for (int i = 0; i < L; i++) r[i] = WB'(v);
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every output valid must match the oldest expected word, on the expected cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rstn && o_sv) begin
            vectors++;
            assert (sb.size() != 0) else begin
                errs++;
                $error("FAIL unexpected_valid: observed sum %0h expected no output", o_si);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("sum_index", o_si, e.data);
                check("latency_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic step(input logic av, input a_t aw, input logic bv, input b_t bw,
                        input logic m, input logic clr);
        logic pop, push;
        exp_t e;
        a_valid = av; a_index = aw; b_valid = bv; b_index = bw; fft_mode = m; clear = clr;
        if (clr) begin
            mq.delete(); m_ov = 1'b0; m_ud = 1'b0;
        end else begin
            pop  = bv && (mq.size() > 0);
            push = av && ((mq.size() < depth_of[sel]) || pop);
            if (bv && mq.size() == 0) m_ud = 1'b1;
            if (av && !push) m_ov = 1'b1;
            if (pop) begin
                e.data = calc(mq.pop_front(), bw, m);
                e.cyc  = cyc + 1;
                sb.push_back(e);
            end
            if (push) mq.push_back(aw);
        end
        @(posedge clk); #1;
        check("fill_level", o_fl, mq.size());
        check("overflow", o_ov, m_ov);
        check("underflow", o_ud, m_ud);
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic switch_to(input int s);
        idle();
        sel = s;
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    endtask

    initial begin
        a_t aw;
        b_t bw;
        logic av, bv;

        // Reset state
        #2;
        check("reset_sum_valid", o_sv, 1'b0);
        check("reset_sum_index", o_si, '0);
        check("reset_fill", o_fl, 0);
        check("reset_overflow", o_ov, 1'b0);
        check("reset_underflow", o_ud, 1'b0);
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;

        // Basic alignment: 176 words of a[lane]=lane, then 176 pops with b=3
        for (int i = 0; i < L; i++) aw[i] = WA'(i);
        for (int k = 0; k < 176; k++) step(1'b1, aw, 1'b0, '0, 1'b1, 1'b0);
        for (int k = 0; k < 176; k++) step(1'b0, '0, 1'b1, all_b(3), 1'b1, 1'b0);
        idle();

        // IFFT conjugate and no-wrap corner
        step(1'b1, all_a(5), 1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, all_b(7), 1'b0, 1'b0);
        step(1'b1, all_a(0), 1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, all_b(0), 1'b0, 1'b0);
        step(1'b1, all_a(31), 1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, all_b(31), 1'b1, 1'b0);
        idle();

        // Full boundary on DEPTH=4
        switch_to(1);
        for (int k = 0; k < 4; k++) step(1'b1, all_a(10 + k), 1'b0, '0, 1'b1, 1'b0);
        step(1'b1, all_a(20), 1'b1, all_b(1), 1'b1, 1'b0);
        step(1'b1, all_a(21), 1'b0, '0, 1'b1, 1'b0);
        idle();

        // Underflow, then clear with a pending push and pop
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
        step(1'b1, all_a(4), 1'b1, all_b(4), 1'b1, 1'b0);
        step(1'b1, all_a(6), 1'b1, all_b(6), 1'b1, 1'b1);
        check("clear_sum_valid", o_sv, 1'b0);
        idle();

        // Asynchronous reset mid-burst on DEPTH=256
        switch_to(0);
        for (int k = 0; k < 3; k++) step(1'b1, all_a(k + 1), 1'b0, '0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b1, all_a(k + 7), 1'b1, all_b(2), 1'b0, 1'b0);
        @(negedge clk); #1;
        rstn = 1'b0;
        #1;
        check("async_sum_valid", o_sv, 1'b0);
        check("async_sum_index", o_si, '0);
        check("async_fill", o_fl, 0);
        check("async_overflow", o_ov, 1'b0);
        check("async_underflow", o_ud, 1'b0);
        mq.delete(); sb.delete(); m_ov = 1'b0; m_ud = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0;
        @(posedge clk); @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;
        step(1'b1, all_a(9), 1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, all_b(4), 1'b1, 1'b0);
        idle();

        // Wrap-around on DEPTH=8 with random lead
        switch_to(2);
        for (int k = 0; k < 50; k++) begin
            for (int i = 0; i < L; i++) begin
                aw[i] = WA'($urandom);
                bw[i] = WB'($urandom);
            end
            av = ($urandom_range(0, 1) == 1) && (mq.size() < 8);
            bv = ($urandom_range(0, 1) == 1) && (mq.size() > 0);
            step(av, aw, bv, bw, 1'($urandom_range(0, 1)), 1'b0);
        end
        while (mq.size() > 0) step(1'b0, '0, 1'b1, all_b(1), 1'b1, 1'b0);
        idle();
        idle();
        check("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
